// File: rtl/ysyx_24100029_btb_sa.sv
// rtl/ysyx_24100029_btb_sa.sv - set-associative branch target buffer (optional BTB_DIR_CNT_EN direction counters)
module ysyx_24100029_btb_sa #(
    parameter int WAYS         = 4,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] btb_pc,
    output logic [31:0] btb_npc,
    output logic [1:0]  btb_br_type,
    output logic        btb_is_hit,
    output logic        btb_pred_taken,
    input  logic        btb_commit,
    input  logic [31:0] btb_commit_pc,
    input  logic [1:0]  btb_commit_pc_type,
    input  logic [31:0] btb_commit_npc,
    input  logic        btb_commit_taken,
    input  logic        btb_flush
);
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_LSB   = OFFSET_WIDTH + INDEX_WIDTH;

    logic [WAYS-1:0]      valid_q  [SETS];
    logic [TAG_WIDTH-1:0] tag_q    [SETS][WAYS];
    logic [1:0]           type_q   [SETS][WAYS];
    logic [31:0]          target_q [SETS][WAYS];
`ifdef BTB_DIR_CNT_EN
    logic [1:0]           cnt_q    [SETS][WAYS];
`endif

    logic [INDEX_WIDTH-1:0] l_idx, c_idx;
    logic [TAG_WIDTH-1:0]   l_tag, c_tag;
    logic                   l_hit, c_hit, c_has_inv, c_alloc, c_write, c_evict;
    logic [WAY_W-1:0]       l_way, c_hit_way, c_inv_way, c_way, rr_ptr_cur;
    logic                   unused_offset;

    assign l_idx = btb_pc[TAG_LSB-1:OFFSET_WIDTH];
    assign l_tag = btb_pc[31:TAG_LSB];
    assign c_idx = btb_commit_pc[TAG_LSB-1:OFFSET_WIDTH];
    assign c_tag = btb_commit_pc[31:TAG_LSB];
    assign unused_offset = ^{btb_pc[OFFSET_WIDTH-1:0], btb_commit_pc[OFFSET_WIDTH-1:0]};

    // Fetch lookup: scan downward so the lowest matching way ends up selected
    always_comb begin
        l_hit = 1'b0;
        l_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = WAY_W'(w);
            end
        end
    end

    assign btb_is_hit  = l_hit;
    assign btb_npc     = l_hit ? target_q[l_idx][l_way] : 32'h0;
    assign btb_br_type = l_hit ? type_q[l_idx][l_way] : 2'b00;
`ifdef BTB_DIR_CNT_EN
    assign btb_pred_taken = l_hit & ((type_q[l_idx][l_way] != 2'b00) | cnt_q[l_idx][l_way][1]);
`else
    assign btb_pred_taken = l_hit;
`endif

    // Commit-side tag match and lowest free way in the committed set
    always_comb begin
        c_hit     = 1'b0;
        c_hit_way = '0;
        c_has_inv = 1'b0;
        c_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[c_idx][w] && tag_q[c_idx][w] == c_tag) begin
                c_hit     = 1'b1;
                c_hit_way = WAY_W'(w);
            end
            if (!valid_q[c_idx][w]) begin
                c_has_inv = 1'b1;
                c_inv_way = WAY_W'(w);
            end
        end
    end

    assign c_alloc = !c_hit && (btb_commit_pc_type != 2'b00 || btb_commit_taken);
    assign c_write = btb_commit && !btb_flush && (c_hit || c_alloc);
    assign c_evict = c_write && c_alloc && !c_has_inv;
    assign c_way   = c_hit ? c_hit_way : (c_has_inv ? c_inv_way : rr_ptr_cur);

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] rr_ptr [SETS];
            // Round-robin pointer moves only when a full set loses an entry
            always_ff @(posedge clock) begin
                if (reset || btb_flush) begin
                    for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
                end else if (c_evict) begin
                    rr_ptr[c_idx] <= rr_ptr[c_idx] + WAY_W'(1);
                end
            end
            assign rr_ptr_cur = rr_ptr[c_idx];
        end else begin : g_no_rr
            assign rr_ptr_cur = '0;
        end
    endgenerate

    // Valid bits: flush/reset clears everything and drops any same-cycle commit
    always_ff @(posedge clock) begin
        if (reset || btb_flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (c_write) begin
            valid_q[c_idx][c_way] <= 1'b1;
        end
    end

    // Entry payload: overwrite on tag hit, fill on allocation; contents survive flush
    always_ff @(posedge clock) begin
        if (!reset && c_write) begin
            tag_q[c_idx][c_way]    <= c_tag;
            type_q[c_idx][c_way]   <= btb_commit_pc_type;
            target_q[c_idx][c_way] <= btb_commit_npc;
`ifdef BTB_DIR_CNT_EN
            if (!c_hit) begin
                cnt_q[c_idx][c_way] <= 2'b10;
            end else if (btb_commit_pc_type == 2'b00) begin
                if (btb_commit_taken && cnt_q[c_idx][c_way] != 2'b11)
                    cnt_q[c_idx][c_way] <= cnt_q[c_idx][c_way] + 2'b01;
                else if (!btb_commit_taken && cnt_q[c_idx][c_way] != 2'b00)
                    cnt_q[c_idx][c_way] <= cnt_q[c_idx][c_way] - 2'b01;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ysyx_24100029_btb_sa.sv
// tb/tb_ysyx_24100029_btb_sa.sv - randomized bench for ysyx_24100029_btb_sa against a behavioural model
module tb_ysyx_24100029_btb_sa;
    localparam int WAYS = 4;
    localparam int SETS = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] btb_pc;
    logic [31:0] btb_npc;
    logic [1:0]  btb_br_type;
    logic        btb_is_hit;
    logic        btb_pred_taken;
    logic        btb_commit;
    logic [31:0] btb_commit_pc;
    logic [1:0]  btb_commit_pc_type;
    logic [31:0] btb_commit_npc;
    logic        btb_commit_taken;
    logic        btb_flush;

    ysyx_24100029_btb_sa #(.WAYS(WAYS), .INDEX_WIDTH(4), .OFFSET_WIDTH(2)) dut (
        .clock(clock), .reset(reset),
        .btb_pc(btb_pc), .btb_npc(btb_npc), .btb_br_type(btb_br_type),
        .btb_is_hit(btb_is_hit), .btb_pred_taken(btb_pred_taken),
        .btb_commit(btb_commit), .btb_commit_pc(btb_commit_pc),
        .btb_commit_pc_type(btb_commit_pc_type), .btb_commit_npc(btb_commit_npc),
        .btb_commit_taken(btb_commit_taken), .btb_flush(btb_flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit        v;
        bit [31:0] pc_hi;
        bit [1:0]  ty;
        bit [31:0] tgt;
        int        cnt;
    } ent_t;

    ent_t mdl [SETS][WAYS];
    int   mrr [SETS];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int set_of(input bit [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < WAYS; w++) mdl[s][w].v = 1'b0;
        end
    endfunction

    function automatic int m_find(input bit [31:0] pc);
        int s = set_of(pc);
        for (int w = 0; w < WAYS; w++)
            if (mdl[s][w].v && mdl[s][w].pc_hi == (pc >> 6)) return w;
        return -1;
    endfunction

    function automatic void m_commit(input bit [31:0] pc, input bit [1:0] ty, input bit [31:0] tgt, input bit tk);
        int s = set_of(pc);
        int w = m_find(pc);
        if (w >= 0) begin
            mdl[s][w].ty  = ty;
            mdl[s][w].tgt = tgt;
            if (ty == 2'b00) begin
                if (tk) mdl[s][w].cnt = (mdl[s][w].cnt == 3) ? 3 : mdl[s][w].cnt + 1;
                else    mdl[s][w].cnt = (mdl[s][w].cnt == 0) ? 0 : mdl[s][w].cnt - 1;
            end
        end else if (ty != 2'b00 || tk) begin
            for (int i = WAYS - 1; i >= 0; i--) if (!mdl[s][i].v) w = i;
            if (w < 0) begin
                w = mrr[s];
                mrr[s] = (mrr[s] + 1) % WAYS;
            end
            mdl[s][w] = '{v: 1'b1, pc_hi: pc >> 6, ty: ty, tgt: tgt, cnt: 2};
        end
    endfunction

    // One clock: drive at negedge, compare outputs against the model's pre-edge state
    task automatic cyc(input bit [31:0] lpc, input bit c, input bit [31:0] cpc, input bit [1:0] cty,
                       input bit [31:0] cnpc, input bit ctk, input bit fl);
        int  w;
        bit  e_hit, e_pred;
        bit [31:0] e_npc;
        bit [1:0]  e_ty;
        @(negedge clock);
        btb_pc = lpc; btb_commit = c; btb_commit_pc = cpc; btb_commit_pc_type = cty;
        btb_commit_npc = cnpc; btb_commit_taken = ctk; btb_flush = fl;
        #1;
        w = m_find(lpc);
        e_hit = (w >= 0);
        e_npc = e_hit ? mdl[set_of(lpc)][w].tgt : 32'h0;
        e_ty  = e_hit ? mdl[set_of(lpc)][w].ty : 2'b00;
`ifdef BTB_DIR_CNT_EN
        e_pred = e_hit && (e_ty != 2'b00 || mdl[set_of(lpc)][w].cnt >= 2);
`else
        e_pred = e_hit;
`endif
        check("hit", {31'h0, btb_is_hit}, {31'h0, e_hit});
        check("npc", btb_npc, e_npc);
        check("type", {30'h0, btb_br_type}, {30'h0, e_ty});
        check("pred", {31'h0, btb_pred_taken}, {31'h0, e_pred});
        if (fl) m_flush();
        else if (c) m_commit(cpc, cty, cnpc, ctk);
    endtask

    task automatic look(input bit [31:0] pc);
        cyc(pc, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic put(input bit [31:0] pc, input bit [1:0] ty, input bit [31:0] tgt, input bit tk);
        cyc(pc, 1'b1, pc, ty, tgt, tk, 1'b0);
    endtask

    initial begin
        bit [31:0] pc;
        reset = 1'b1; btb_pc = 32'h0; btb_commit = 1'b0; btb_commit_pc = 32'h0;
        btb_commit_pc_type = 2'b00; btb_commit_npc = 32'h0; btb_commit_taken = 1'b0; btb_flush = 1'b0;
        m_flush();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        look(32'h8000_0000);
        check("rst_hit", {31'h0, btb_is_hit}, 32'h0);
        check("rst_npc", btb_npc, 32'h0);

        put(32'h8000_0010, 2'b01, 32'h8000_0100, 1'b0);
        check("same_cycle_hit", {31'h0, btb_is_hit}, 32'h0);
        look(32'h8000_0010);
        check("alloc_npc", btb_npc, 32'h8000_0100);
        check("alloc_pred", {31'h0, btb_pred_taken}, 32'h1);

        for (int i = 0; i < 5; i++) put(32'h8000_0000 + 32'(i) * 32'h40, 2'b01, 32'h9000_0000 + 32'(i), 1'b0);
        look(32'h8000_0000);
        check("evict_w0", {31'h0, btb_is_hit}, 32'h0);
        for (int i = 1; i < 5; i++) look(32'h8000_0000 + 32'(i) * 32'h40);
        put(32'h8000_0040, 2'b10, 32'h1234_5678, 1'b0);
        look(32'h8000_0040);
        check("upd_npc", btb_npc, 32'h1234_5678);
        put(32'h8000_0140, 2'b01, 32'h5555_0000, 1'b0);
        look(32'h8000_0040);
        check("ptr_kept_w1", {31'h0, btb_is_hit}, 32'h0);
        look(32'h8000_0080);
        check("w2_alive", {31'h0, btb_is_hit}, 32'h1);

        put(32'h8000_0014, 2'b00, 32'h8000_0800, 1'b1);
        look(32'h8000_0014);
        check("cnt_new_pred", {31'h0, btb_pred_taken}, 32'h1);
        put(32'h8000_0014, 2'b00, 32'h8000_0804, 1'b0);
        put(32'h8000_0014, 2'b00, 32'h8000_0808, 1'b0);
        look(32'h8000_0014);
        check("nt_hit", {31'h0, btb_is_hit}, 32'h1);
        check("nt_npc", btb_npc, 32'h8000_0808);
`ifdef BTB_DIR_CNT_EN
        check("cnt00_pred", {31'h0, btb_pred_taken}, 32'h0);
`endif
        for (int i = 0; i < 4; i++) put(32'h8000_0014, 2'b00, 32'h8000_0800, 1'b1);
        put(32'h8000_0014, 2'b00, 32'h8000_0800, 1'b0);
        look(32'h8000_0014);
        check("cnt_sat_pred", {31'h0, btb_pred_taken}, 32'h1);

        put(32'h8000_0038, 2'b00, 32'h8000_0900, 1'b0);
        look(32'h8000_0038);
        check("nt_miss_noalloc", {31'h0, btb_is_hit}, 32'h0);

        cyc(32'h8000_0080, 1'b1, 32'h8000_0200, 2'b01, 32'h7777_0000, 1'b0, 1'b1);
        look(32'h8000_0080);
        check("flush_miss", {31'h0, btb_is_hit}, 32'h0);
        look(32'h8000_0200);
        check("flush_drop", {31'h0, btb_is_hit}, 32'h0);
        for (int i = 0; i < 5; i++) put(32'h8000_1000 + 32'(i) * 32'h40, 2'b11, 32'hA000_0000 + 32'(i), 1'b0);
        look(32'h8000_1000);
        check("flush_rr_w0", {31'h0, btb_is_hit}, 32'h0);
        look(32'h8000_1040);
        check("flush_rr_w1", {31'h0, btb_is_hit}, 32'h1);

        for (int i = 0; i < 3000; i++) begin
            pc = 32'h8000_0000 + (32'($urandom_range(0, 7)) << 6) + (32'($urandom_range(0, 3)) << 2);
            cyc(($urandom_range(0, 3) == 0) ? pc :
                    32'h8000_0000 + (32'($urandom_range(0, 7)) << 6) + (32'($urandom_range(0, 3)) << 2),
                $urandom_range(0, 1) == 1, pc, 2'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
